// File: rtl/plab4_net_arb_mux.sv
// Round-robin arbitrating mux merging two val/rdy domains into one registered
// stream tagged with its source domain for the downstream demux select.
module plab4_net_arb_mux #(
    parameter int unsigned p_msg_cnbits = 32,
    parameter int unsigned p_msg_dnbits = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    in_val_d1,
    output logic                    in_rdy_d1,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d1,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d1,

    input  logic                    in_val_d2,
    output logic                    in_rdy_d2,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d2,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d2,

    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [p_msg_cnbits-1:0] out_msg_control,
    output logic [p_msg_dnbits-1:0] out_msg_data,
    output logic                    domain
);

    logic                    out_val_q, out_val_d;
    logic                    domain_q, domain_d;
    logic                    prio_q, prio_d;
    logic [p_msg_cnbits-1:0] control_q, control_d;
    logic [p_msg_dnbits-1:0] data_q, data_d;

    logic load_c;
    logic fire_d1_c;
    logic fire_d2_c;

    // Handshake: ready never depends on a domain's own valid; held low in reset.
    always_comb begin
        load_c    = !out_val_q || out_rdy;
        in_rdy_d1 = reset && load_c && (!prio_q || !in_val_d2);
        in_rdy_d2 = reset && load_c && ( prio_q || !in_val_d1);
        fire_d1_c = in_val_d1 && in_rdy_d1;
        fire_d2_c = in_val_d2 && in_rdy_d2;
    end

    // Next-state: fields are only muxed from a firing side, so idle inputs never leak.
    always_comb begin
        out_val_d = out_val_q;
        domain_d  = domain_q;
        prio_d    = prio_q;
        control_d = control_q;
        data_d    = data_q;
        if (load_c) begin
            if (fire_d1_c) begin
                out_val_d = 1'b1;
                domain_d  = 1'b0;
                prio_d    = 1'b1;
                control_d = in_msg_control_d1;
                data_d    = in_msg_data_d1;
            end else if (fire_d2_c) begin
                out_val_d = 1'b1;
                domain_d  = 1'b1;
                prio_d    = 1'b0;
                control_d = in_msg_control_d2;
                data_d    = in_msg_data_d2;
            end else begin
                out_val_d = 1'b0;
                control_d = '0;
                data_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val_q <= 1'b0;
            domain_q  <= 1'b0;
            prio_q    <= 1'b0;
            control_q <= '0;
            data_q    <= '0;
        end else begin
            out_val_q <= out_val_d;
            domain_q  <= domain_d;
            prio_q    <= prio_d;
            control_q <= control_d;
            data_q    <= data_d;
        end
    end

    assign out_val         = out_val_q;
    assign domain          = domain_q;
    assign out_msg_control = control_q;
    assign out_msg_data    = data_q;

endmodule

// File: tb/tb_plab4_net_arb_mux.sv
// Directed bench for plab4_net_arb_mux: reset, streaming, contention,
// backpressure, idle scrub and asynchronous mid-transfer reset.
module tb_plab4_net_arb_mux;

    localparam int unsigned CW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic          in_val_d1, in_rdy_d1;
    logic [CW-1:0] in_msg_control_d1;
    logic [DW-1:0] in_msg_data_d1;
    logic          in_val_d2, in_rdy_d2;
    logic [CW-1:0] in_msg_control_d2;
    logic [DW-1:0] in_msg_data_d2;
    logic          out_val, out_rdy;
    logic [CW-1:0] out_msg_control;
    logic [DW-1:0] out_msg_data;
    logic          domain;

    int n_checks;
    int n_fails;

    plab4_net_arb_mux #(.p_msg_cnbits(CW), .p_msg_dnbits(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_val_d1         (in_val_d1),
        .in_rdy_d1         (in_rdy_d1),
        .in_msg_control_d1 (in_msg_control_d1),
        .in_msg_data_d1    (in_msg_data_d1),
        .in_val_d2         (in_val_d2),
        .in_rdy_d2         (in_rdy_d2),
        .in_msg_control_d2 (in_msg_control_d2),
        .in_msg_data_d2    (in_msg_data_d2),
        .out_val           (out_val),
        .out_rdy           (out_rdy),
        .out_msg_control   (out_msg_control),
        .out_msg_data      (out_msg_data),
        .domain            (domain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic d, input logic [DW-1:0] data);
        chk({tag, ".val"}, 64'(out_val), 64'(v));
        chk({tag, ".dom"}, 64'(domain), 64'(d));
        chk({tag, ".data"}, 64'(out_msg_data), 64'(data));
    endtask

    task automatic chk_rdy(input string tag, input logic r1, input logic r2);
        chk({tag, ".rdy1"}, 64'(in_rdy_d1), 64'(r1));
        chk({tag, ".rdy2"}, 64'(in_rdy_d2), 64'(r2));
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;

        // Reset held with both domains valid
        reset = 1'b0;
        out_rdy = 1'b1;
        in_val_d1 = 1'b1; in_msg_data_d1 = 32'h000000C1; in_msg_control_d1 = 32'h00000101;
        in_val_d2 = 1'b1; in_msg_data_d2 = 32'h000000D1; in_msg_control_d2 = 32'h00000201;
        #3;
        chk_out("rst", 1'b0, 1'b0, 32'h0);
        chk_rdy("rst", 1'b0, 1'b0);
        tick();
        tick();
        chk_out("rst_hold", 1'b0, 1'b0, 32'h0);
        chk("rst_hold.ctl", 64'(out_msg_control), 64'h0);
        reset = 1'b1;
        #1;
        chk_rdy("rel", 1'b1, 1'b0);
        tick();
        chk_out("first", 1'b1, 1'b0, 32'hC1);
        chk("first.ctl", 64'(out_msg_control), 64'h101);

        // Single-domain stream; idle d2 carries X fields
        in_val_d2 = 1'b0; in_msg_data_d2 = 'x; in_msg_control_d2 = 'x;
        in_msg_data_d1 = 32'h11;
        #1;
        chk_rdy("s1", 1'b1, 1'b1);
        tick();
        chk_out("s11", 1'b1, 1'b0, 32'h11);
        in_msg_data_d1 = 32'h22;
        tick();
        chk_out("s22", 1'b1, 1'b0, 32'h22);
        in_msg_data_d1 = 32'h33;
        tick();
        chk_out("s33", 1'b1, 1'b0, 32'h33);
        in_val_d1 = 1'b0;
        tick();
        chk_out("s_idle", 1'b0, 1'b0, 32'h0);

        // Lone d2 message then idle scrub with X on both idle inputs
        in_val_d2 = 1'b1; in_msg_data_d2 = 32'hDEAD; in_msg_control_d2 = 32'h0000BEEF;
        tick();
        chk_out("dead", 1'b1, 1'b1, 32'hDEAD);
        chk("dead.ctl", 64'(out_msg_control), 64'hBEEF);
        in_val_d2 = 1'b0;
        in_msg_data_d1 = 'x; in_msg_control_d1 = 'x;
        in_msg_data_d2 = 'x; in_msg_control_d2 = 'x;
        tick();
        chk_out("scrub", 1'b0, 1'b1, 32'h0);
        chk("scrub.ctl", 64'(out_msg_control), 64'h0);

        // Contention alternation (prio back at d1 after the lone d2 message)
        in_val_d1 = 1'b1; in_msg_data_d1 = 32'hA0; in_msg_control_d1 = 32'h1;
        in_val_d2 = 1'b1; in_msg_data_d2 = 32'hB0; in_msg_control_d2 = 32'h2;
        #1;
        chk_rdy("c0", 1'b1, 1'b0);
        tick();
        chk_out("cA0", 1'b1, 1'b0, 32'hA0);
        chk_rdy("c1", 1'b0, 1'b1);
        in_msg_data_d1 = 32'hA1;
        tick();
        chk_out("cB0", 1'b1, 1'b1, 32'hB0);
        in_msg_data_d2 = 32'hB1;
        tick();
        chk_out("cA1", 1'b1, 1'b0, 32'hA1);
        in_msg_data_d1 = 32'hA2;
        tick();
        chk_out("cB1", 1'b1, 1'b1, 32'hB1);
        in_msg_data_d2 = 32'hB5;
        tick();
        chk_out("cA2", 1'b1, 1'b0, 32'hA2);
        in_msg_data_d1 = 32'hA3;
        tick();
        chk_out("cB5", 1'b1, 1'b1, 32'hB5);

        // Backpressure holds d2 message for three cycles
        out_rdy = 1'b0;
        #1;
        chk_rdy("bp0", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp", 1'b1, 1'b1, 32'hB5);
            chk_rdy("bp", 1'b0, 1'b0);
        end
        out_rdy = 1'b1;
        #1;
        chk_rdy("bp_rel", 1'b1, 1'b0);
        tick();
        chk_out("bp_A3", 1'b1, 1'b0, 32'hA3);
        in_val_d1 = 1'b0;
        in_val_d2 = 1'b0;
        tick();
        chk_out("bp_idle", 1'b0, 1'b0, 32'h0);

        // Asynchronous reset while a message sits in the output register
        in_val_d1 = 1'b1; in_msg_data_d1 = 32'h77; in_msg_control_d1 = 32'h7;
        tick();
        chk_out("m77", 1'b1, 1'b0, 32'h77);
        in_val_d1 = 1'b0;
        out_rdy = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_out("mrst", 1'b0, 1'b0, 32'h0);
        chk("mrst.ctl", 64'(out_msg_control), 64'h0);
        #1;
        reset = 1'b1;
        out_rdy = 1'b1;
        tick();
        chk_out("mrst_idle", 1'b0, 1'b0, 32'h0);
        in_val_d1 = 1'b1; in_msg_data_d1 = 32'h81;
        in_val_d2 = 1'b1; in_msg_data_d2 = 32'h82; in_msg_control_d2 = 32'h8;
        #1;
        chk_rdy("mrst_prio", 1'b1, 1'b0);
        tick();
        chk_out("mrst_d1", 1'b1, 1'b0, 32'h81);
        in_val_d1 = 1'b0;
        tick();
        chk_out("mrst_d2", 1'b1, 1'b1, 32'h82);
        in_val_d2 = 1'b0;
        tick();
        chk_out("end_idle", 1'b0, 1'b1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/plab4_net_arb_mux.md
Name: plab4_net_arb_mux

Overview:
- Two-domain arbitrating multiplexer that sits directly upstream of the network demux.
- Merges the domain-1 and domain-2 val/rdy message streams into one registered stream.
- The output stream carries a domain tag that drives the demux select.
- Round-robin arbitration between domains; one-cycle registered latency; full throughput of 1 message/cycle.

Parameters:
- p_msg_cnbits, 32, width of the control field of a message
- p_msg_dnbits, 32, width of the data field of a message

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous active-low reset (asserted when 0)
- in_val_d1  input  1  domain-1 message valid
- in_rdy_d1  output  1  domain-1 message accepted this cycle when high with in_val_d1
- in_msg_control_d1  input  p_msg_cnbits  domain-1 control field
- in_msg_data_d1  input  p_msg_dnbits  domain-1 data field
- in_val_d2  input  1  domain-2 message valid
- in_rdy_d2  output  1  domain-2 ready
- in_msg_control_d2  input  p_msg_cnbits  domain-2 control field
- in_msg_data_d2  input  p_msg_dnbits  domain-2 data field
- out_val  output  1  registered output valid
- out_rdy  input  1  downstream (demux) ready
- out_msg_control  output  p_msg_cnbits  registered control field
- out_msg_data  output  p_msg_dnbits  registered data field
- domain  output  1  registered tag; 0 = message from d1, 1 = message from d2

Behaviour:
- Reset (reset=0, asynchronous): out_val=0, domain=0, out_msg_control=0, out_msg_data=0, priority pointer prio=0 (d1 favoured). Takes effect immediately and mid-transfer; any in-flight message is dropped.
- Output register is a single pipeline stage. load = !out_val || out_rdy.
- Grant (combinational):
  - grant_d1 = in_val_d1 && (!in_val_d2 || prio==0)
  - grant_d2 = in_val_d2 && (!in_val_d1 || prio==1)
  - Grants are mutually exclusive.
- Ready: in_rdy_d1 = load && (prio==0 || !in_val_d2); in_rdy_d2 = load && (prio==1 || !in_val_d1).
  - Ready may depend on the other domain's valid, never on its own valid.
  - in_rdy_dX is never high for the non-granted side when both sides are valid.
- Transfer: fire_dX = in_val_dX && in_rdy_dX.
- On a clock edge with load=1:
  - fire_d1: out_val<=1, domain<=0, control/data <= d1 fields, prio<=1.
  - fire_d2: out_val<=1, domain<=1, control/data <= d2 fields, prio<=0.
  - No fire: out_val<=0, out_msg_control<=0, out_msg_data<=0, domain holds. Stale data from one domain must not remain visible while idle.
- With load=0 (out_val=1, out_rdy=0): all output registers and prio hold; both in_rdy are 0.
- prio changes only on a transfer. An uncontended transfer still updates prio, so after a lone d1 message, d2 wins the next tie.
- Latency: message accepted in cycle N appears on out_* in cycle N+1. Back-to-back transfers continue with no bubble while out_rdy=1.
- Simultaneous drain and fill: out_rdy=1 with out_val=1 and a new fire in the same cycle replaces the output register contents in one edge; there is no bubble.
- Fields are passed through unmodified; no width conversion or arithmetic on message fields.
- X on inputs while the corresponding in_val is 0 must not propagate to out_* (gate the mux with the grant).

Test Plan:
- Reset: hold reset=0 with in_val_d1=1, in_val_d2=1 → out_val=0, domain=0, out_msg_data=0, in_rdy_d1=in_rdy_d2=0. Release reset → next edge accepts d1 first (prio=0).
- Single domain stream: d1 sends data 0x11,0x22,0x33 back-to-back, out_rdy=1 → out_msg_data 0x11,0x22,0x33 in consecutive cycles starting 1 cycle later, domain=0 each, no bubbles.
- Contention alternation: both valid continuously, d1 data 0xA0.., d2 data 0xB0.., out_rdy=1 → output sequence A0,B0,A1,B1 with domain 0,1,0,1.
- Backpressure: output holds d2 message 0xB5, out_rdy=0 for 3 cycles → out_msg_data=0xB5, domain=1, in_rdy_d1=in_rdy_d2=0 throughout. The next cycle with out_rdy=1 accepts d1 (prio=0).
- Idle scrub: a single d2 message 0xDEAD drained, no further valids → next cycle out_val=0, out_msg_data=0, out_msg_control=0, domain stays 1.
- Mid-transfer reset: reset asserted asynchronously between edges while out_val=1 → out_val drops immediately, prio=0, and no message appears after release until a new fire.
